// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Used by pipe_hazard_ctrl and hazard_detect.
package pipe_pkg;

   localparam int REG_AW = 5;
   localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERR      = 2'd2
   } state_t;

   // True when a nonzero source register is written by an in-flight producer.
   function automatic logic reg_match(input logic [REG_AW-1:0] src,
                                      input logic [REG_AW-1:0] dest,
                                      input logic              wb_en);
      return wb_en && (src != REG_ZERO) && (src == dest);
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational RAW hazard equation for the ID stage.
// PIPE_HAZARD_CTRL_FWD_EN selects the forwarding-aware (load-use only) rule.
module hazard_detect
   import pipe_pkg::*;
(
   input  logic [REG_AW-1:0] src1,
   input  logic [REG_AW-1:0] src2,
   input  logic              two_src,
   input  logic [REG_AW-1:0] exe_dest,
   input  logic              exe_wb_en,
   input  logic              exe_mem_r_en,
   input  logic [REG_AW-1:0] mem_dest,
   input  logic              mem_wb_en,
   output logic              hazard
);

`ifdef PIPE_HAZARD_CTRL_FWD_EN
   // Forwarding covers ALU results; only a load in EXE cannot be bypassed in time.
   logic load_in_exe;
   logic unused_mem_fields;

   assign load_in_exe       = exe_mem_r_en & exe_wb_en;
   assign unused_mem_fields = ^{mem_dest, mem_wb_en};

   assign hazard = reg_match(src1, exe_dest, load_in_exe) |
                   (two_src & reg_match(src2, exe_dest, load_in_exe));
`else
   logic unused_exe_mem_r_en;
   logic src1_hit;
   logic src2_hit;

   assign unused_exe_mem_r_en = exe_mem_r_en;

   assign src1_hit = reg_match(src1, exe_dest, exe_wb_en) |
                     reg_match(src1, mem_dest, mem_wb_en);
   assign src2_hit = reg_match(src2, exe_dest, exe_wb_en) |
                     reg_match(src2, mem_dest, mem_wb_en);

   assign hazard = src1_hit | (two_src & src2_hit);
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: stage enables/flushes, memory-wait FSM with
// timeout watchdog, and a saturating stall counter. Macro: PIPE_HAZARD_CTRL_FWD_EN.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] src1,
   input  logic [REG_AW-1:0] src2,
   input  logic              two_src,
   input  logic              br_taken,
   input  logic [REG_AW-1:0] exe_dest,
   input  logic              exe_wb_en,
   input  logic              exe_mem_r_en,
   input  logic [REG_AW-1:0] mem_dest,
   input  logic              mem_wb_en,
   input  logic              mem_req,
   input  logic              mem_ready,
   output logic              pc_en,
   output logic              ifid_en,
   output logic              ifid_flush,
   output logic              idex_flush,
   output logic              exmem_en,
   output logic              memwb_bubble,
   output logic              mem_err,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   state_t            state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              hazard;
   logic              freeze;

   hazard_detect u_hazard_detect (
      .src1         (src1),
      .src2         (src2),
      .two_src      (two_src),
      .exe_dest     (exe_dest),
      .exe_wb_en    (exe_wb_en),
      .exe_mem_r_en (exe_mem_r_en),
      .mem_dest     (mem_dest),
      .mem_wb_en    (mem_wb_en),
      .hazard       (hazard)
   );

   assign freeze = (mem_req & ~mem_ready) | (state == ERR);

   // A pending branch stays in ID/EX during a freeze, so freeze must outrank it.
   always_comb begin
      pc_en        = 1'b1;
      ifid_en      = 1'b1;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      exmem_en     = 1'b1;
      memwb_bubble = 1'b0;
      if (freeze) begin
         pc_en        = 1'b0;
         ifid_en      = 1'b0;
         exmem_en     = 1'b0;
         memwb_bubble = 1'b1;
      end else if (br_taken) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (hazard) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= RUN;
         wait_cnt <= '0;
         mem_err  <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               wait_cnt <= '0;
               if (mem_req && !mem_ready) begin
                  state <= MEM_WAIT;
               end
            end
            MEM_WAIT: begin
               if (mem_ready) begin
                  state    <= RUN;
                  wait_cnt <= '0;
               end else if (wait_cnt == WAIT_LAST) begin
                  state   <= ERR;
                  mem_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            ERR: begin
               state <= ERR;
            end
            default: begin
               state    <= RUN;
               wait_cnt <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (!pc_en && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule
